// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared UART definitions used by the receive and transmit sides.
//   UART_OVERSAMPLE : oversample ticks per bit period (default for both sides)
//   UART_DATA_BITS  : payload bits per frame (8N1 framing)
//   uart_state_e    : serial-engine FSM state encodings
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage : uart_rx_pkg

// File: rtl/baud_tick.sv
// -----------------------------------------------------------------------------
// baud_tick
// Free-running oversample tick generator. The counter runs 0..CLKS_PER_TICK-1
// and wraps; tick is high for the single cycle in which the counter holds its
// terminal value.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; clears the counter
//   tick  : one-cycle oversample strobe
// -----------------------------------------------------------------------------
module baud_tick #(
  parameter int CLKS_PER_TICK = 78
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  // A one-clock tick period still needs a 1-bit counter to stay legal.
  localparam int CNT_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_TICK - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule : baud_tick

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, oversampled at OVERSAMPLE ticks per bit.
// The start bit is qualified at mid-bit; data and stop bits are then sampled
// one full bit period apart, i.e. at the centre of each bit.
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high
//   rx        : asynchronous serial input, idle high
//   dout      : last correctly framed byte; held until the next rx_done
//   rx_done   : one-cycle strobe, dout valid in the same cycle (FIFO write)
//   frame_err : one-cycle strobe, stop bit sampled low
//   state_o   : current FSM state, for debug and checker binding
//
// Strobe semantics: rx_done and frame_err are fire-and-forget pulses with no
// back-pressure. The consumer must capture dout in the cycle rx_done is high;
// the two strobes are mutually exclusive and never last more than one cycle.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_TICK = 78,
  parameter int OVERSAMPLE    = UART_OVERSAMPLE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [7:0]  dout,
  output logic        rx_done,
  output logic        frame_err,
  output uart_state_e state_o
);

  localparam int TCNT_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(UART_DATA_BITS);

  localparam logic [TCNT_W-1:0] TCNT_HALF = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] TCNT_FULL = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(UART_DATA_BITS - 1);

  // Two-flop synchronizer, preset to the idle level so reset never looks
  // like a start edge.
  logic rx_meta_q;
  logic rx_s_q;

  logic tick;

  uart_state_e       state_q;
  logic [TCNT_W-1:0] tcnt_q;
  logic [BCNT_W-1:0] bcnt_q;
  logic [7:0]        shreg_q;
  logic [7:0]        dout_q;
  logic              rx_done_q;
  logic              frame_err_q;

  baud_tick #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      shreg_q     <= '0;
      dout_q      <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          // Start-edge detection is not gated by tick so a start bit that
          // follows the stop-bit sample directly is not missed.
          if (!rx_s_q) begin
            state_q <= ST_START;
            tcnt_q  <= '0;
          end
        end

        ST_START: begin
          if (tick) begin
            if (tcnt_q == TCNT_HALF) begin
              tcnt_q <= '0;
              bcnt_q <= '0;
              // Line back high at mid-start-bit is a glitch: drop it silently.
              state_q <= rx_s_q ? ST_IDLE : ST_DATA;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (tcnt_q == TCNT_FULL) begin
              tcnt_q  <= '0;
              shreg_q <= {rx_s_q, shreg_q[7:1]};
              if (bcnt_q == BCNT_LAST) begin
                bcnt_q  <= '0;
                state_q <= ST_STOP;
              end else begin
                bcnt_q <= bcnt_q + 1'b1;
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (tcnt_q == TCNT_FULL) begin
              tcnt_q <= '0;
              if (rx_s_q) begin
                dout_q    <= shreg_q;
                rx_done_q <= 1'b1;
                state_q   <= ST_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= ST_BREAK;
              end
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end

        ST_BREAK: begin
          // Wait out a held-low line so it reports a single framing error.
          if (rx_s_q) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout      = dout_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign state_o   = state_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed and randomized frames driven onto rx. A frame-level model decides
// what each transmitted frame must produce: a valid stop bit yields one
// received byte and updates the expected dout; a low stop bit yields one
// framing error and leaves dout alone; a line held low for any length beyond
// one frame yields exactly one framing error. Observed strobes are logged by a
// monitor and matched against the expected event queue in order.
// Event encoding: {1'b0, byte} = byte received, {1'b1, 8'h00} = framing error.
// -----------------------------------------------------------------------------
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int CPT      = 2;
  localparam int OS       = 16;
  localparam int BIT_CLKS = CPT * OS;
  localparam int W        = 9;

  logic        clk;
  logic        reset;
  logic        rx;
  logic [7:0]  dout;
  logic        rx_done;
  logic        frame_err;
  uart_state_e state_o;

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_TICK(CPT),
    .OVERSAMPLE   (OS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .dout     (dout),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .state_o  (state_o)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           rd_idx;
  logic [7:0]   model_dout;
  int           n_cmp;
  int           n_err;

  // Monitor: logs strobes and counts protocol violations (overlap, >1 cycle).
  int   overlap_cnt;
  int   long_cnt;
  logic prev_done;
  logic prev_err;

  initial begin
    overlap_cnt = 0;
    long_cnt    = 0;
    prev_done   = 1'b0;
    prev_err    = 1'b0;
  end

  always @(negedge clk) begin
    if (rx_done && frame_err) overlap_cnt++;
    if ((rx_done && prev_done) || (frame_err && prev_err)) long_cnt++;
    if (rx_done) obs_q.push_back({1'b0, dout});
    if (frame_err) obs_q.push_back({1'b1, 8'h00});
    prev_done = rx_done;
    prev_err  = frame_err;
  end

  // ---------------------------------------------------------------- drivers
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle_clks(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame and records what the model says it must produce.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    if (stop) begin
      exp_q.push_back({1'b0, b});
      model_dout = b;
    end else begin
      exp_q.push_back({1'b1, 8'h00});
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input uart_state_e exp);
    n_cmp++;
    assert (state_o === exp) else begin
      n_err++;
      $error("FAIL %s: observed state %0d expected %0d", tag, state_o, exp);
    end
  endtask

  task automatic check_dout(input string tag);
    n_cmp++;
    assert (dout === model_dout) else begin
      n_err++;
      $error("FAIL %s_dout: observed %h expected %h", tag, dout, model_dout);
    end
  endtask

  task automatic check_events(input string tag);
    int n_obs;
    n_obs = obs_q.size() - rd_idx;
    n_cmp++;
    assert (n_obs === exp_q.size()) else begin
      n_err++;
      $error("FAIL %s_count: observed %0d events expected %0d", tag, n_obs, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < n_obs) begin
        n_cmp++;
        assert (obs_q[rd_idx + i] === exp_q[i]) else begin
          n_err++;
          $error("FAIL %s_ev%0d: observed %h expected %h", tag, i, obs_q[rd_idx + i], exp_q[i]);
        end
      end
    end
    rd_idx = obs_q.size();
    exp_q.delete();
    check_dout(tag);
    n_cmp++;
    assert (overlap_cnt === 0) else begin
      n_err++;
      $error("FAIL %s_overlap: observed %0d expected 0", tag, overlap_cnt);
    end
    n_cmp++;
    assert (long_cnt === 0) else begin
      n_err++;
      $error("FAIL %s_width: observed %0d expected 0", tag, long_cnt);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [7:0] rb;
    logic       rs;
    n_cmp      = 0;
    n_err      = 0;
    rd_idx     = 0;
    model_dout = 8'h00;
    rx         = 1'b1;
    reset      = 1'b1;
    repeat (4) @(negedge clk);

    // Reset state.
    check_dout("rst");
    check_bit("rst_rx_done", rx_done, 1'b0);
    check_bit("rst_frame_err", frame_err, 1'b0);
    check_state("rst_state", ST_IDLE);

    reset = 1'b0;
    idle_clks(BIT_CLKS);

    // Single good frame.
    send_frame(8'hA5, 1'b1);
    idle_clks(BIT_CLKS);
    check_events("a5");

    // Start glitch of 4 ticks: rejected, then a normal frame.
    rx = 1'b0;
    repeat (4 * CPT) @(negedge clk);
    idle_clks(2 * BIT_CLKS);
    check_state("glitch_state", ST_IDLE);
    check_events("glitch");
    send_frame(8'h5A, 1'b1);
    idle_clks(BIT_CLKS);
    check_events("5a");

    // Bad stop bit: one framing error, dout keeps 0x5A.
    send_frame(8'h33, 1'b0);
    idle_clks(2 * BIT_CLKS);
    check_state("ferr_state", ST_IDLE);
    check_events("ferr");

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_clks(BIT_CLKS);
    check_events("b2b");

    // Reset after 4 data bits of 0x81: frame abandoned, outputs cleared.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    model_dout = 8'h00;
    check_dout("midrst");
    check_bit("midrst_rx_done", rx_done, 1'b0);
    check_bit("midrst_frame_err", frame_err, 1'b0);
    check_state("midrst_state", ST_IDLE);
    rx    = 1'b1;
    reset = 1'b0;
    idle_clks(2 * BIT_CLKS);
    check_events("midrst_quiet");
    send_frame(8'h3C, 1'b1);
    idle_clks(BIT_CLKS);
    check_events("3c");

    // Line held low for three frame times: exactly one framing error.
    rx = 1'b0;
    repeat (30 * BIT_CLKS) @(negedge clk);
    exp_q.push_back({1'b1, 8'h00});
    idle_clks(2 * BIT_CLKS);
    check_state("break_state", ST_IDLE);
    check_events("break");

    // Randomized frames, occasional bad stop bits, random gaps (including none).
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs);
      if (rs) idle_clks($urandom_range(0, 2) * $urandom_range(0, BIT_CLKS));
      else    idle_clks(BIT_CLKS + $urandom_range(0, BIT_CLKS));
    end
    idle_clks(2 * BIT_CLKS);
    check_events("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_rx
